// File: rtl/alu_share_arbiter.sv
// Round-robin share of one single-cycle ALU between two requesters.
// A granted op is registered, presented to the ALU for one cycle, and its
// tagged result is held until the consumer takes it. Each requester has a
// saturating count of its completed ops.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk__i,
  input  logic                  rst__i,
  input  logic [1:0]            reqValid__i,
  output logic [1:0]            reqReady__o,
  input  logic [2*DATA_W-1:0]   reqA__i,
  input  logic [2*DATA_W-1:0]   reqB__i,
  input  logic [2*CTRL_W-1:0]   reqCtrl__i,
  input  logic [2*TAG_W-1:0]    reqTag__i,
  output logic [DATA_W-1:0]     aluA__o,
  output logic [DATA_W-1:0]     aluB__o,
  output logic [CTRL_W-1:0]     aluCtrl__o,
  input  logic [DATA_W-1:0]     aluResult__i,
  input  logic                  aluZero__i,
  output logic                  rspValid__o,
  input  logic                  rspReady__i,
  output logic [DATA_W-1:0]     rspResult__o,
  output logic                  rspZero__o,
  output logic                  rspErr__o,
  output logic                  rspId__o,
  output logic [TAG_W-1:0]      rspTag__o,
  output logic [CNT_W-1:0]      opCnt0__o,
  output logic [CNT_W-1:0]      opCnt1__o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                last_grant_q;
  logic                grant_id_c;
  logic                issue_c;
  logic                legal_c;

  logic [DATA_W-1:0]   op_a_q;
  logic [DATA_W-1:0]   op_b_q;
  logic [CTRL_W-1:0]   op_ctrl_q;
  logic [TAG_W-1:0]    op_tag_q;
  logic                op_id_q;

  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic                rsp_zero_q;
  logic                rsp_err_q;
  logic                rsp_id_q;
  logic [TAG_W-1:0]    rsp_tag_q;
  logic [CNT_W-1:0]    cnt0_q;
  logic [CNT_W-1:0]    cnt1_q;

  // State register
  always_ff @(posedge clk__i) begin
    if (rst__i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and grant; ready is offered only in IDLE, never gated by rspReady
  always_comb begin
    state_d     = state_q;
    reqReady__o = 2'b00;
    grant_id_c  = 1'b0;
    issue_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reqValid__i == 2'b11) grant_id_c = ~last_grant_q;
        else                      grant_id_c = reqValid__i[1];
        if (reqValid__i != 2'b00) begin
          issue_c     = 1'b1;
          reqReady__o = grant_id_c ? 2'b10 : 2'b01;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: state_d = S_RESP;
      S_RESP: if (rspReady__i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Legal ALU control codes: ADD, SUB, AND, OR, SLT
  always_comb begin
    legal_c = (op_ctrl_q == CTRL_W'(3'b010)) || (op_ctrl_q == CTRL_W'(3'b110)) ||
              (op_ctrl_q == CTRL_W'(3'b000)) || (op_ctrl_q == CTRL_W'(3'b001)) ||
              (op_ctrl_q == CTRL_W'(3'b111));
  end

  // Op capture on accept, result capture after the BUSY cycle, counters, response handshake
  always_ff @(posedge clk__i) begin
    if (rst__i) begin
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_ctrl_q    <= '0;
      op_tag_q     <= '0;
      op_id_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_tag_q    <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      if (issue_c) begin
        op_a_q       <= grant_id_c ? reqA__i[2*DATA_W-1:DATA_W] : reqA__i[DATA_W-1:0];
        op_b_q       <= grant_id_c ? reqB__i[2*DATA_W-1:DATA_W] : reqB__i[DATA_W-1:0];
        op_ctrl_q    <= grant_id_c ? reqCtrl__i[2*CTRL_W-1:CTRL_W] : reqCtrl__i[CTRL_W-1:0];
        op_tag_q     <= grant_id_c ? reqTag__i[2*TAG_W-1:TAG_W] : reqTag__i[TAG_W-1:0];
        op_id_q      <= grant_id_c;
        last_grant_q <= grant_id_c;
      end
      if (state_q == S_BUSY) begin
        rsp_valid_q  <= 1'b1;
        rsp_result_q <= aluResult__i;
        rsp_zero_q   <= aluZero__i;
        rsp_err_q    <= ~legal_c;
        rsp_id_q     <= op_id_q;
        rsp_tag_q    <= op_tag_q;
        if (!op_id_q && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
        if (op_id_q && (cnt1_q != '1))  cnt1_q <= cnt1_q + CNT_W'(1);
      end
      if ((state_q == S_RESP) && rspReady__i) rsp_valid_q <= 1'b0;
    end
  end

  assign aluA__o      = op_a_q;
  assign aluB__o      = op_b_q;
  assign aluCtrl__o   = op_ctrl_q;
  assign rspValid__o  = rsp_valid_q;
  assign rspResult__o = rsp_result_q;
  assign rspZero__o   = rsp_zero_q;
  assign rspErr__o    = rsp_err_q;
  assign rspId__o     = rsp_id_q;
  assign rspTag__o    = rsp_tag_q;
  assign opCnt0__o    = cnt0_q;
  assign opCnt1__o    = cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed ops with a behavioural ALU, a scoreboard
// of expected responses and a negedge monitor that pops on each handshake.
module tb_alu_share_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned CNT_W  = 2;

  localparam logic [2:0] C_ADD = 3'b010;
  localparam logic [2:0] C_SUB = 3'b110;
  localparam logic [2:0] C_AND = 3'b000;
  localparam logic [2:0] C_SLT = 3'b111;
  localparam logic [2:0] C_BAD = 3'b011;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
    logic        id;
    logic [3:0]  tag;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [2*DATA_W-1:0]  req_a;
  logic [2*DATA_W-1:0]  req_b;
  logic [2*CTRL_W-1:0]  req_ctrl;
  logic [2*TAG_W-1:0]   req_tag;
  logic [DATA_W-1:0]    alu_a;
  logic [DATA_W-1:0]    alu_b;
  logic [CTRL_W-1:0]    alu_ctrl;
  logic [DATA_W-1:0]    alu_res;
  logic                 alu_zero;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_result;
  logic                 rsp_zero;
  logic                 rsp_err;
  logic                 rsp_id;
  logic [TAG_W-1:0]     rsp_tag;
  logic [CNT_W-1:0]     cnt0;
  logic [CNT_W-1:0]     cnt1;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  alu_share_arbiter #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk__i(clk),             .rst__i(rst),
    .reqValid__i(req_valid),  .reqReady__o(req_ready),
    .reqA__i(req_a),          .reqB__i(req_b),
    .reqCtrl__i(req_ctrl),    .reqTag__i(req_tag),
    .aluA__o(alu_a),          .aluB__o(alu_b),
    .aluCtrl__o(alu_ctrl),    .aluResult__i(alu_res),
    .aluZero__i(alu_zero),    .rspValid__o(rsp_valid),
    .rspReady__i(rsp_ready),  .rspResult__o(rsp_result),
    .rspZero__o(rsp_zero),    .rspErr__o(rsp_err),
    .rspId__o(rsp_id),        .rspTag__o(rsp_tag),
    .opCnt0__o(cnt0),         .opCnt1__o(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; an illegal code yields A^B
  always_comb begin
    case (alu_ctrl)
      3'b010:  alu_res = alu_a + alu_b;
      3'b110:  alu_res = alu_a - alu_b;
      3'b000:  alu_res = alu_a & alu_b;
      3'b001:  alu_res = alu_a | alu_b;
      3'b111:  alu_res = 32'($signed(alu_a) < $signed(alu_b));
      default: alu_res = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_res == 32'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic e, input logic id, input logic [3:0] t);
    exp_t x;
    x.result = r;
    x.zero   = (r == 32'd0);
    x.err    = e;
    x.id     = id;
    x.tag    = t;
    return x;
  endfunction

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input logic [3:0] t);
    if (idx == 0) begin
      req_a[31:0] = a; req_b[31:0] = b; req_ctrl[2:0] = c; req_tag[3:0] = t;
    end else begin
      req_a[63:32] = a; req_b[63:32] = b; req_ctrl[5:3] = c; req_tag[7:4] = t;
    end
  endtask

  // Present one request, wait (bounded) for its ready, return just after the accept edge
  task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] c, input logic [3:0] t);
    bit got = 1'b0;
    @(posedge clk); #1;
    set_req(idx, a, b, c, t);
    req_valid[idx] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready[idx]) begin got = 1'b1; break; end
    end
    if (!got) chk("send_ready_timeout", 64'(req_ready), 64'(2'b01 << idx));
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) begin done = 1'b1; break; end
    end
    if (!done) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: stability under backpressure, no ready while a response is pending, scoreboard pop
  initial begin
    exp_t held;
    exp_t cur;
    exp_t e;
    bit   hold_prev;
    hold_prev = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      cur = '{result: rsp_result, zero: rsp_zero, err: rsp_err, id: rsp_id, tag: rsp_tag};
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (rsp_valid) chk("ready_while_resp", 64'(req_ready), 64'd0);
        if (hold_prev && rsp_valid) chk("rsp_stable", 64'(cur), 64'(held));
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 64'(cur), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_result", 64'(rsp_result), 64'(e.result));
            chk("rsp_zero",   64'(rsp_zero),   64'(e.zero));
            chk("rsp_err",    64'(rsp_err),    64'(e.err));
            chk("rsp_id",     64'(rsp_id),     64'(e.id));
            chk("rsp_tag",    64'(rsp_tag),    64'(e.tag));
          end
        end
        hold_prev = rsp_valid && !rsp_ready;
        held      = cur;
      end
    end
  end

  // Watchdog
  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0;
    int   n1;
    bit   got;
    logic [1:0] exp_rdy;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_ctrl  = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_cnt0",      64'(cnt0),      64'd0);
    chk("rst_cnt1",      64'(cnt1),      64'd0);
    chk("rst_alu",       64'({alu_a, alu_ctrl}), 64'd0);
    chk("rst_ready",     64'(req_ready), 64'd0);

    // Single op: 5+3, latency 2
    sb.push_back(mk(32'd8, 1'b0, 1'b0, 4'd7));
    send(0, 32'd5, 32'd3, C_ADD, 4'd7);
    @(negedge clk);
    chk("lat_n1_valid", 64'(rsp_valid), 64'd0);
    chk("busy_alu_a",   64'(alu_a),     64'd5);
    @(negedge clk);
    chk("lat_n2_valid", 64'(rsp_valid), 64'd1);
    wait_drain();
    chk("single_cnt0", 64'(cnt0), 64'd1);

    // Tie from reset: grants 0,1,0,1, all SUB 4-4
    do_reset();
    sb.push_back(mk(32'd0, 1'b0, 1'b0, 4'd1));
    sb.push_back(mk(32'd0, 1'b0, 1'b1, 4'd9));
    sb.push_back(mk(32'd0, 1'b0, 1'b0, 4'd2));
    sb.push_back(mk(32'd0, 1'b0, 1'b1, 4'd10));
    set_req(0, 32'd4, 32'd4, C_SUB, 4'd1);
    set_req(1, 32'd4, 32'd4, C_SUB, 4'd9);
    req_valid = 2'b11;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin got = 1'b1; break; end
      end
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("tie_grant", 64'(req_ready), 64'(exp_rdy));
      if (!got) break;
      @(posedge clk); #1;
      if (exp_rdy[0]) begin
        n0++;
        req_tag[3:0] = 4'd2;
        if (n0 == 2) req_valid[0] = 1'b0;
      end else begin
        n1++;
        req_tag[7:4] = 4'd10;
        if (n1 == 2) req_valid[1] = 1'b0;
      end
    end
    req_valid = 2'b00;
    wait_drain();
    chk("tie_cnt0", 64'(cnt0), 64'd2);
    chk("tie_cnt1", 64'(cnt1), 64'd2);

    // Backpressure: 0xF0 & 0x3C held 5+ cycles, req1 SLT(-1,1) waits
    rsp_ready = 1'b0;
    sb.push_back(mk(32'h30, 1'b0, 1'b0, 4'd3));
    sb.push_back(mk(32'd1, 1'b0, 1'b1, 4'd5));
    send(0, 32'hF0, 32'h3C, C_AND, 4'd3);
    set_req(1, 32'hFFFF_FFFF, 32'd1, C_SLT, 4'd5);
    req_valid[1] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    chk("bp_rsp_seen", 64'(got), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready_low", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_grant", 64'(req_ready), 64'(2'b10));
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_drain();
    chk("bp_cnt0", 64'(cnt0), 64'd3);
    chk("bp_cnt1", 64'(cnt1), 64'd3);

    // Illegal ctrl from req1: 6^3 from the ALU, err set, still counted
    do_reset();
    sb.push_back(mk(32'd5, 1'b1, 1'b1, 4'd12));
    send(1, 32'd6, 32'd3, C_BAD, 4'd12);
    wait_drain();
    chk("bad_cnt1", 64'(cnt1), 64'd1);
    chk("bad_cnt0", 64'(cnt0), 64'd0);

    // Saturation with a 2-bit counter
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      sb.push_back(mk(32'(2 * k), 1'b0, 1'b0, 4'(k)));
      send(0, 32'(k), 32'(k), C_ADD, 4'(k));
      wait_drain();
      chk("sat_cnt0", 64'(cnt0), 64'((k < 3) ? k : 3));
    end

    // Reset while BUSY drops the op; next tie goes to req0
    send(0, 32'd1, 32'd2, C_ADD, 4'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rbusy_valid", 64'(rsp_valid), 64'd0);
    chk("rbusy_cnt0",  64'(cnt0),      64'd0);
    chk("rbusy_alu_a", 64'(alu_a),     64'd0);
    req_valid = 2'b11;
    #1;
    chk("rbusy_tie", 64'(req_ready), 64'(2'b01));
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    chk("rbusy_no_rsp", 64'(rsp_valid), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
